grf_wb_ctrl: RTL and testbench

- Write-port driver for the GRF; it is the producer side of the GRF's WA/WD/RegWrite/PC interface.
- Merges two result sources:
  - in-order pipeline writeback, which is never stalled;
  - a late-result source (slow load, multi-cycle unit) with a valid/ready handshake, buffered in a small FIFO.
- Emits at most one registered GRF write per cycle.
- Keeps a pending-write scoreboard that decode uses to stall on registers awaiting a late result.

---
 rtl/grf_wb_ctrl_if.sv | 57 +++++
 rtl/grf_wb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_grf_wb_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_wb_ctrl_if.sv
// GRF write-port bundle: pipeline writeback, late-result handshake,
// scoreboard marking and the registered GRF write outputs.
//
// Signals:
//   pipe_we/pipe_wa/pipe_wd/pipe_pc   pipeline writeback (never stalled)
//   late_valid/late_ready             late-result handshake
//   late_wa/late_wd/late_pc           late-result payload
//   mark_valid/mark_wa                decode marks a pending late write
//   WA/WD/RegWrite/PC                 registered GRF write port
//   pending                           per-register outstanding late write
//   fifo_count                        late-result FIFO occupancy
//
// slave  : the write-port controller
// master : whoever drives the pipeline/late/mark side
interface grf_wb_ctrl_if #(
    parameter int PTR_W = 2
);
    logic             pipe_we;
    logic [4:0]       pipe_wa;
    logic [31:0]      pipe_wd;
    logic [31:0]      pipe_pc;

    logic             late_valid;
    logic             late_ready;
    logic [4:0]       late_wa;
    logic [31:0]      late_wd;
    logic [31:0]      late_pc;

    logic             mark_valid;
    logic [4:0]       mark_wa;

    logic [4:0]       WA;
    logic [31:0]      WD;
    logic             RegWrite;
    logic [31:0]      PC;

    logic [31:0]      pending;
    logic [PTR_W:0]   fifo_count;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, pipe_pc,
        input  late_valid, late_wa, late_wd, late_pc,
        output late_ready,
        input  mark_valid, mark_wa,
        output WA, WD, RegWrite, PC,
        output pending, fifo_count
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd, pipe_pc,
        output late_valid, late_wa, late_wd, late_pc,
        input  late_ready,
        output mark_valid, mark_wa,
        input  WA, WD, RegWrite, PC,
        input  pending, fifo_count
    );
endinterface

// File: rtl/grf_wb_ctrl.sv
// GRF write-port driver: merges the never-stalled pipeline writeback with
// a FIFO-buffered late-result source and emits one registered GRF write.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   wb     grf_wb_ctrl_if.slave (pipeline, late handshake, mark, GRF out)
//
// Parameters:
//   DEPTH  late-result FIFO entries (power of two, 2..16)
//   PTR_W  log2(DEPTH)
//
// Build option:
//   GRF_WB_BYPASS_EN  when defined, a late result arriving while the FIFO
//                     is empty and the pipeline slot is free is written
//                     straight to the GRF on its handshake edge.
module grf_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    grf_wb_ctrl_if.slave wb
);

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } wb_ent_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] CNT_ZERO = '0;

    // FIFO storage and pointers
    wb_ent_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // registered GRF write port
    wb_ent_t          out_q, out_d;
    logic             we_q, we_d;

    // scoreboard
    logic [31:0]      pend_q, pend_d;

    // decoded controls
    logic             pipe_hit;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             byp;
    wb_ent_t          head;
    wb_ent_t          pipe_ent;
    wb_ent_t          late_ent;
    logic [31:0]      set_m;
    logic [31:0]      clr_m;

    assign pipe_hit   = wb.pipe_we && (wb.pipe_wa != 5'd0);
    assign fifo_empty = (count_q == CNT_ZERO);
    assign head       = mem_q[rd_ptr_q];

    assign pipe_ent = '{wa: wb.pipe_wa, wd: wb.pipe_wd, pc: wb.pipe_pc};
    assign late_ent = '{wa: wb.late_wa, wd: wb.late_wd, pc: wb.late_pc};

    // Ready is a function of the registered count only, so a pop on the
    // same edge never opens a slot for a push while full.
    assign wb.late_ready = !reset && (count_q < FULL_CNT);
    assign accept        = wb.late_valid && wb.late_ready;

`ifdef GRF_WB_BYPASS_EN
    assign byp = accept && fifo_empty && !pipe_hit
              && (wb.late_wa != 5'd0);
`else
    assign byp = 1'b0;
`endif

    // r0 results are swallowed by the handshake; bypassed ones skip the FIFO
    assign push = accept && (wb.late_wa != 5'd0) && !byp;
    assign pop  = !pipe_hit && !fifo_empty;

    // Output select: pipeline first, then FIFO head, then bypass
    always_comb begin
        out_d = out_q;
        we_d  = 1'b0;
        if (pipe_hit) begin
            out_d = pipe_ent;
            we_d  = 1'b1;
        end else if (pop) begin
            out_d = head;
            we_d  = 1'b1;
        end else if (byp) begin
            out_d = late_ent;
            we_d  = 1'b1;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q
                + {{PTR_W{1'b0}}, push}
                - {{PTR_W{1'b0}}, pop};
    end

    // Scoreboard: set applied after clear so a same-edge mark wins
    always_comb begin
        set_m = 32'd0;
        clr_m = 32'd0;
        if (wb.mark_valid && (wb.mark_wa != 5'd0)) begin
            set_m = 32'd1 << wb.mark_wa;
        end
        if (pop) begin
            clr_m = 32'd1 << head.wa;
        end else if (byp) begin
            clr_m = 32'd1 << wb.late_wa;
        end
        pend_d = ((pend_q & ~clr_m) | set_m) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            we_q     <= 1'b0;
            pend_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            we_q     <= we_d;
            pend_q   <= pend_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= late_ent;
        end
    end

    assign wb.WA         = out_q.wa;
    assign wb.WD         = out_q.wd;
    assign wb.PC         = out_q.pc;
    assign wb.RegWrite   = we_q;
    assign wb.pending    = pend_q;
    assign wb.fifo_count = count_q;

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Self-checking bench for grf_wb_ctrl: table of pipeline vectors plus
// hand-written late-result sequences, with a write-order scoreboard.
module tb_grf_wb_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    grf_wb_ctrl_if #(.PTR_W(2)) wb ();

    grf_wb_ctrl #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] epc;
    } vec_t;

    wr_t  sbq [$];
    vec_t vt [6];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_lat;
    int   lat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(logic [4:0] wa, logic [31:0] wd, logic [31:0] pc);
        wr_t e;
        e.wa = wa;
        e.wd = wd;
        e.pc = pc;
        sbq.push_back(e);
    endtask

    // advance one edge, then score any GRF write against the queue
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (wb.RegWrite === 1'b1) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got write WA=%0d WD=%h", wb.WA, wb.WD);
            end else begin
                e = sbq.pop_front();
                if (wb.WA !== e.wa || wb.WD !== e.wd || wb.PC !== e.pc) begin
                    n_err++;
                    $display("FAIL sb_write: got %0d/%h/%h expected %0d/%h/%h",
                             wb.WA, wb.WD, wb.PC, e.wa, e.wd, e.pc);
                end
            end
        end
    endtask

    task automatic clr_in();
        wb.pipe_we    = 1'b0;
        wb.pipe_wa    = 5'd0;
        wb.pipe_wd    = 32'd0;
        wb.pipe_pc    = 32'd0;
        wb.late_valid = 1'b0;
        wb.late_wa    = 5'd0;
        wb.late_wd    = 32'd0;
        wb.late_pc    = 32'd0;
        wb.mark_valid = 1'b0;
        wb.mark_wa    = 5'd0;
    endtask

    task automatic drv_pipe(logic we, logic [4:0] wa, logic [31:0] wd, logic [31:0] pc);
        wb.pipe_we = we;
        wb.pipe_wa = wa;
        wb.pipe_wd = wd;
        wb.pipe_pc = pc;
    endtask

    task automatic drv_late(logic v, logic [4:0] wa, logic [31:0] wd, logic [31:0] pc);
        wb.late_valid = v;
        wb.late_wa    = wa;
        wb.late_wd    = wd;
        wb.late_pc    = pc;
    endtask

    initial begin
`ifdef GRF_WB_BYPASS_EN
        exp_lat = 1;
`else
        exp_lat = 2;
`endif
        vt[0] = '{1'b1, 5'd5,  32'h1234,     32'h3000, 1'b1, 5'd5,  32'h1234,     32'h3000};
        vt[1] = '{1'b1, 5'd31, 32'hdeadbeef, 32'h3004, 1'b1, 5'd31, 32'hdeadbeef, 32'h3004};
        vt[2] = '{1'b0, 5'd7,  32'h1111,     32'h3008, 1'b0, 5'd31, 32'hdeadbeef, 32'h3004};
        vt[3] = '{1'b1, 5'd0,  32'h2222,     32'h300c, 1'b0, 5'd31, 32'hdeadbeef, 32'h3004};
        vt[4] = '{1'b1, 5'd1,  32'hffffffff, 32'h3010, 1'b1, 5'd1,  32'hffffffff, 32'h3010};
        vt[5] = '{1'b0, 5'd2,  32'h5555,     32'h3014, 1'b0, 5'd1,  32'hffffffff, 32'h3010};

        // reset held two cycles while a late result is offered
        clr_in();
        reset = 1'b1;
        drv_late(1'b1, 5'd9, 32'h99, 32'h9000);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_ready", {31'd0, wb.late_ready}, 32'd0);
        end
        chk("reset_regwrite", {31'd0, wb.RegWrite}, 32'd0);
        chk("reset_pending", wb.pending, 32'd0);
        chk("reset_count", {29'd0, wb.fifo_count}, 32'd0);
        chk("reset_wa", {27'd0, wb.WA}, 32'd0);
        clr_in();
        reset = 1'b0;
        step();

        // pipeline vectors
        for (int i = 0; i < 6; i++) begin
            drv_pipe(vt[i].we, vt[i].wa, vt[i].wd, vt[i].pc);
            if (vt[i].rw) exp_push(vt[i].ewa, vt[i].ewd, vt[i].epc);
            step();
            chk($sformatf("vec%0d_rw", i), {31'd0, wb.RegWrite}, {31'd0, vt[i].rw});
            chk($sformatf("vec%0d_wa", i), {27'd0, wb.WA}, {27'd0, vt[i].ewa});
            chk($sformatf("vec%0d_wd", i), wb.WD, vt[i].ewd);
            chk($sformatf("vec%0d_pc", i), wb.PC, vt[i].epc);
        end
        clr_in();
        step();

        // fill FIFO while the pipeline owns every slot
        for (int k = 0; k < 4; k++) begin
            drv_pipe(1'b1, 5'd3, 32'h300 + k, 32'h7000 + 4 * k);
            drv_late(1'b1, 5'(8 + k), 32'ha0 + k, 32'h8000 + 4 * k);
            exp_push(5'd3, 32'h300 + k, 32'h7000 + 4 * k);
            #1;
            chk($sformatf("fill%0d_ready", k), {31'd0, wb.late_ready}, 32'd1);
            step();
        end
        drv_pipe(1'b1, 5'd3, 32'h304, 32'h7010);
        drv_late(1'b1, 5'd12, 32'hbad, 32'hbad0);
        exp_push(5'd3, 32'h304, 32'h7010);
        #1;
        chk("full_ready", {31'd0, wb.late_ready}, 32'd0);
        chk("full_count", {29'd0, wb.fifo_count}, 32'd4);
        step();
        chk("full_count_hold", {29'd0, wb.fifo_count}, 32'd4);
        clr_in();
        for (int k = 0; k < 4; k++) begin
            exp_push(5'(8 + k), 32'ha0 + k, 32'h8000 + 4 * k);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("drain%0d_rw", k), {31'd0, wb.RegWrite}, 32'd1);
            chk($sformatf("drain%0d_wa", k), {27'd0, wb.WA}, 8 + k);
        end
        step();
        chk("drain_done_rw", {31'd0, wb.RegWrite}, 32'd0);
        chk("drain_done_count", {29'd0, wb.fifo_count}, 32'd0);

        // scoreboard mark then late write clears it
        wb.mark_valid = 1'b1;
        wb.mark_wa    = 5'd7;
        step();
        wb.mark_valid = 1'b0;
        chk("mark7_pending", wb.pending, 32'h80);
        drv_late(1'b1, 5'd7, 32'h77, 32'h4000);
        exp_push(5'd7, 32'h77, 32'h4000);
        step();
        lat = 1;
        clr_in();
        while (wb.RegWrite !== 1'b1 && lat < 4) begin
            step();
            lat++;
        end
        chk("late7_rw", {31'd0, wb.RegWrite}, 32'd1);
        chk("late7_latency", lat, exp_lat);
        chk("late7_pending", wb.pending, 32'd0);

        // same-edge mark and emit of r7: set wins
        wb.mark_valid = 1'b1;
        wb.mark_wa    = 5'd7;
        step();
        chk("remark7_pending", wb.pending, 32'h80);
        wb.mark_valid = 1'b0;
        exp_push(5'd7, 32'h78, 32'h4004);
`ifdef GRF_WB_BYPASS_EN
        drv_late(1'b1, 5'd7, 32'h78, 32'h4004);
        wb.mark_valid = 1'b1;
        step();
`else
        drv_late(1'b1, 5'd7, 32'h78, 32'h4004);
        step();
        clr_in();
        wb.mark_valid = 1'b1;
        wb.mark_wa    = 5'd7;
        step();
`endif
        clr_in();
        chk("same_edge_rw", {31'd0, wb.RegWrite}, 32'd1);
        chk("same_edge_wa", {27'd0, wb.WA}, 32'd7);
        chk("same_edge_pending", wb.pending, 32'h80);

        // pipe_wa==0 slot lets the FIFO drain
        drv_pipe(1'b1, 5'd3, 32'h333, 32'h6000);
        drv_late(1'b1, 5'd4, 32'h444, 32'h6004);
        exp_push(5'd3, 32'h333, 32'h6000);
        exp_push(5'd4, 32'h444, 32'h6004);
        step();
        clr_in();
        drv_pipe(1'b1, 5'd0, 32'heeee, 32'h6008);
        step();
        chk("r0slot_rw", {31'd0, wb.RegWrite}, 32'd1);
        chk("r0slot_wa", {27'd0, wb.WA}, 32'd4);
        chk("r0slot_count", {29'd0, wb.fifo_count}, 32'd0);
        clr_in();

        // late write to r0 is accepted and dropped
        drv_late(1'b1, 5'd0, 32'h5a5a, 32'h6100);
        #1;
        chk("late0_ready", {31'd0, wb.late_ready}, 32'd1);
        step();
        clr_in();
        chk("late0_count", {29'd0, wb.fifo_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("late0_idle%0d", k), {31'd0, wb.RegWrite}, 32'd0);
        end

        // idle block: handshake-to-write latency for r12
        drv_late(1'b1, 5'd12, 32'hc0c0, 32'h5000);
        exp_push(5'd12, 32'hc0c0, 32'h5000);
        step();
        lat = 1;
        clr_in();
        while (wb.RegWrite !== 1'b1 && lat < 4) begin
            step();
            lat++;
        end
        chk("late12_latency", lat, exp_lat);
        chk("late12_wa", {27'd0, wb.WA}, 32'd12);
        step();

        // reset mid-operation drops buffered results and pending bits
        drv_pipe(1'b1, 5'd3, 32'h900, 32'h9100);
        drv_late(1'b1, 5'd20, 32'h920, 32'h9200);
        exp_push(5'd3, 32'h900, 32'h9100);
        step();
        drv_pipe(1'b1, 5'd3, 32'h901, 32'h9104);
        drv_late(1'b1, 5'd21, 32'h921, 32'h9204);
        exp_push(5'd3, 32'h901, 32'h9104);
        step();
        chk("mid_count", {29'd0, wb.fifo_count}, 32'd2);
        clr_in();
        reset = 1'b1;
        step();
        chk("mid_reset_count", {29'd0, wb.fifo_count}, 32'd0);
        chk("mid_reset_pending", wb.pending, 32'd0);
        chk("mid_reset_rw", {31'd0, wb.RegWrite}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_reset_rw%0d", k), {31'd0, wb.RegWrite}, 32'd0);
        end

        chk("sb_leftover", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
